// File: rtl/dqpsk_mod_if.sv
// Handshake and sample bus of the DQPSK transmitter: dibit input side plus
// passband sample and status outputs. valid/ready transfer on a clock edge with both high.
interface dqpsk_mod_if;
    logic [1:0]        din;
    logic              din_valid;
    logic              din_ready;
    logic signed [7:0] dout;
    logic              busy;
    logic              sym_strobe;
    logic              underrun;

    modport master (
        output din, din_valid,
        input  din_ready, dout, busy, sym_strobe, underrun
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, busy, sym_strobe, underrun
    );
endinterface

// File: rtl/dqpsk_mod.sv
// DQPSK transmitter: differential Gray dibit encoding, rectangular SPS-sample
// symbols, fs/4 up-conversion via the I, -Q, -I, Q sample sequence.
module dqpsk_mod #(
    parameter int SPS = 32,
    parameter int AMP = 90
) (
    input logic        clk,
    input logic        reset_n,
    dqpsk_mod_if.slave bus
);
    localparam int                CW       = $clog2(SPS);
    localparam logic [CW-1:0]     CNT_LAST = CW'(SPS - 1);
    localparam logic signed [7:0] A_POS    = 8'(AMP);
    localparam logic signed [7:0] A_NEG    = 8'(-AMP);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        p_q, p_d;
    logic [1:0]        c_q, c_d;
    logic [1:0]        buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              busy_q, busy_d;
    logic              sym_strobe_q, sym_strobe_d;
    logic              underrun_q, underrun_d;
    logic signed [7:0] dout_q, dout_d;

    logic [1:0]        inc;
    logic signed [7:0] m;
    logic              i_pos, q_pos, last, load;

    always_comb begin
        case (buf_q)
            2'b00:   inc = 2'd0;
            2'b01:   inc = 2'd1;
            2'b11:   inc = 2'd2;
            default: inc = 2'd3;
        endcase

        // Sign of each axis for phase p; the carrier just picks and negates.
        i_pos = (p_q == 2'd0) || (p_q == 2'd3);
        q_pos = !p_q[1];
        case (c_q)
            2'd0:    m = i_pos ? A_POS : A_NEG;
            2'd1:    m = q_pos ? A_NEG : A_POS;
            2'd2:    m = i_pos ? A_NEG : A_POS;
            default: m = q_pos ? A_POS : A_NEG;
        endcase

        last = (cnt_q == CNT_LAST);
        load = buf_full_q && ((state_q == IDLE) || last);

        state_d      = state_q;
        cnt_d        = cnt_q;
        p_d          = p_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        sym_strobe_d = 1'b0;
        underrun_d   = 1'b0;
        c_d          = c_q + 2'd1;
        dout_d       = (state_q == RUN) ? m : 8'sd0;

        // Ready is !buf_full_q, so a write and a consume never share an edge.
        if (bus.din_valid && !buf_full_q) begin
            buf_d      = bus.din;
            buf_full_d = 1'b1;
        end

        if (load) begin
            p_d          = p_q + inc;
            buf_full_d   = 1'b0;
            cnt_d        = '0;
            state_d      = RUN;
            sym_strobe_d = 1'b1;
        end else if (state_q == RUN) begin
            if (last) begin
                state_d    = IDLE;
                cnt_d      = '0;
                underrun_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            p_q          <= 2'd0;
            c_q          <= 2'd0;
            buf_q        <= 2'd0;
            buf_full_q   <= 1'b0;
            busy_q       <= 1'b0;
            sym_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
            dout_q       <= 8'sd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p_q          <= p_d;
            c_q          <= c_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            busy_q       <= busy_d;
            sym_strobe_q <= sym_strobe_d;
            underrun_q   <= underrun_d;
            dout_q       <= dout_d;
        end
    end

    assign bus.din_ready  = !buf_full_q;
    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.sym_strobe = sym_strobe_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_dqpsk_mod.sv
// Directed bench for dqpsk_mod (SPS=32, AMP=90): reset, single symbol, stream,
// backpressure, boundary underrun and mid-symbol reset.
module tb_dqpsk_mod;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   cyc;

    dqpsk_mod_if bus ();

    dqpsk_mod #(.SPS(32), .AMP(90)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release; its low two bits are the carrier phase.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic signed [7:0] exp_m(input logic [1:0] p, input logic [1:0] c);
        logic signed [7:0] i_v, q_v;
        case (p)
            2'd0:    begin i_v = 8'sd90;  q_v = 8'sd90;  end
            2'd1:    begin i_v = -8'sd90; q_v = 8'sd90;  end
            2'd2:    begin i_v = -8'sd90; q_v = -8'sd90; end
            default: begin i_v = 8'sd90;  q_v = -8'sd90; end
        endcase
        case (c)
            2'd0:    return i_v;
            2'd1:    return -q_v;
            2'd2:    return -i_v;
            default: return q_v;
        endcase
    endfunction

    task automatic do_reset();
        bus.din_valid = 1'b0;
        bus.din       = 2'b00;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (bus.dout !== 8'sd0 || bus.busy !== 1'b0 || bus.din_ready !== 1'b1 ||
                bus.sym_strobe !== 1'b0 || bus.underrun !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: dout=%0d busy=%b ready=%b strobe=%b underrun=%b expected 0 0 1 0 0",
                         cyc, bus.dout, bus.busy, bus.din_ready, bus.sym_strobe, bus.underrun);
            end
        end
    endtask

    task automatic test_single();
        logic signed [7:0] e;
        do_reset();
        @(negedge clk);
        bus.din = 2'b00; bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        checks++;
        if (bus.din_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: ready=%b busy=%b expected 0 0", bus.din_ready, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.sym_strobe !== 1'b1 || bus.busy !== 1'b1 || bus.dout !== 8'sd0) begin
            errors++;
            $display("FAIL single_load: strobe=%b busy=%b dout=%0d expected 1 1 0",
                     bus.sym_strobe, bus.busy, bus.dout);
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = exp_m(2'd0, 2'(cyc - 1));
            checks++;
            if (bus.dout !== e || bus.sym_strobe !== 1'b0) begin
                errors++;
                $display("FAIL single_sample k=%0d: dout=%0d strobe=%b expected %0d 0", k, bus.dout, bus.sym_strobe, e);
            end
            checks++;
            if (bus.underrun !== (k == 31) || bus.busy !== (k != 31)) begin
                errors++;
                $display("FAIL single_end k=%0d: underrun=%b busy=%b expected %b %b",
                         k, bus.underrun, bus.busy, k == 31, k != 31);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.dout !== 8'sd0 || bus.underrun !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: dout=%0d underrun=%b busy=%b expected 0 0 0", bus.dout, bus.underrun, bus.busy);
        end
    endtask

    task automatic test_stream();
        logic [1:0] seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        logic [1:0] ep  [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2};
        int t0, l1, n, k;
        logic signed [7:0] e;
        logic es, eu, eb;
        do_reset();
        repeat (3) @(negedge clk);
        t0 = cyc;
        l1 = t0 + 2;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    int budget;
                    bus.din = seq[i]; bus.din_valid = 1'b1;
                    budget = 0;
                    while (!bus.din_ready && budget < 100) begin
                        @(negedge clk);
                        budget++;
                    end
                    @(negedge clk);
                end
                bus.din_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 2 + 5 * 32 + 1; j++) begin
                    @(negedge clk);
                    n  = cyc;
                    k  = (n - l1 - 1) / 32;
                    e  = (n >= l1 + 1 && n <= l1 + 160) ? exp_m(ep[k], 2'(n - 1)) : 8'sd0;
                    es = (n >= l1 && n < l1 + 160 && ((n - l1) % 32) == 0);
                    eu = (n == l1 + 160);
                    eb = (n >= l1 && n < l1 + 160);
                    checks++;
                    if (bus.dout !== e) begin
                        errors++;
                        $display("FAIL stream_dout n=%0d: dout=%0d expected %0d", n - t0, bus.dout, e);
                    end
                    checks++;
                    if (bus.sym_strobe !== es || bus.underrun !== eu || bus.busy !== eb) begin
                        errors++;
                        $display("FAIL stream_flags n=%0d: strobe=%b underrun=%b busy=%b expected %b %b %b",
                                 n - t0, bus.sym_strobe, bus.underrun, bus.busy, es, eu, eb);
                    end
                end
            end
        join
    endtask

    task automatic test_backpressure();
        logic [1:0] seq [6] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01};
        logic [1:0] ep  [6] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2};
        int t0, l1, n, k;
        logic signed [7:0] e;
        logic er;
        do_reset();
        repeat (2) @(negedge clk);
        t0 = cyc;
        l1 = t0 + 2;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int budget;
                    bus.din = seq[i]; bus.din_valid = 1'b1;
                    budget = 0;
                    while (!bus.din_ready && budget < 100) begin
                        @(negedge clk);
                        budget++;
                    end
                    @(negedge clk);
                end
                bus.din_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 2 + 6 * 32 + 1; j++) begin
                    @(negedge clk);
                    n  = cyc;
                    k  = (n - l1 - 1) / 32;
                    e  = (n >= l1 + 1 && n <= l1 + 192) ? exp_m(ep[k], 2'(n - 1)) : 8'sd0;
                    er = (n >= l1 + 160) || (n >= l1 && ((n - l1) % 32) == 0);
                    checks++;
                    if (bus.din_ready !== er) begin
                        errors++;
                        $display("FAIL bp_ready n=%0d: din_ready=%b expected %b", n - t0, bus.din_ready, er);
                    end
                    checks++;
                    if (bus.dout !== e) begin
                        errors++;
                        $display("FAIL bp_dout n=%0d: dout=%0d expected %0d", n - t0, bus.dout, e);
                    end
                end
            end
        join
    endtask

    task automatic test_gap();
        int t0;
        logic signed [7:0] e;
        do_reset();
        @(negedge clk);
        t0 = cyc;
        bus.din = 2'b01; bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        repeat (32) begin
            @(negedge clk);
            e = (cyc == t0 + 2) ? 8'sd0 : exp_m(2'd1, 2'(cyc - 1));
            checks++;
            if (bus.dout !== e) begin
                errors++;
                $display("FAIL gap_first n=%0d: dout=%0d expected %0d", cyc - t0, bus.dout, e);
            end
        end
        checks++;
        if (bus.din_ready !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_pre: ready=%b busy=%b expected 1 1", bus.din_ready, bus.busy);
        end
        bus.din = 2'b11; bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        e = exp_m(2'd1, 2'(cyc - 1));
        checks++;
        if (bus.underrun !== 1'b1 || bus.busy !== 1'b0 || bus.din_ready !== 1'b0 || bus.dout !== e) begin
            errors++;
            $display("FAIL gap_boundary: underrun=%b busy=%b ready=%b dout=%0d expected 1 0 0 %0d",
                     bus.underrun, bus.busy, bus.din_ready, bus.dout, e);
        end
        @(negedge clk);
        checks++;
        if (bus.dout !== 8'sd0 || bus.sym_strobe !== 1'b1 || bus.busy !== 1'b1 || bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL gap_zero: dout=%0d strobe=%b busy=%b underrun=%b expected 0 1 1 0",
                     bus.dout, bus.sym_strobe, bus.busy, bus.underrun);
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = exp_m(2'd3, 2'(cyc - 1));
            checks++;
            if (bus.dout !== e || bus.underrun !== (k == 31)) begin
                errors++;
                $display("FAIL gap_second k=%0d: dout=%0d underrun=%b expected %0d %b",
                         k, bus.dout, bus.underrun, e, k == 31);
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        logic signed [7:0] e;
        do_reset();
        @(negedge clk);
        bus.din = 2'b11; bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din = 2'b01;
        budget = 0;
        while (!bus.din_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
        repeat (8) @(negedge clk);
        e = exp_m(2'd2, 2'(cyc - 1));
        checks++;
        if (bus.busy !== 1'b1 || bus.din_ready !== 1'b0 || bus.dout !== e) begin
            errors++;
            $display("FAIL mid_before: busy=%b ready=%b dout=%0d expected 1 0 %0d", bus.busy, bus.din_ready, bus.dout, e);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 8'sd0 || bus.busy !== 1'b0 || bus.din_ready !== 1'b1 ||
            bus.sym_strobe !== 1'b0 || bus.underrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: dout=%0d busy=%b ready=%b strobe=%b underrun=%b expected 0 0 1 0 0",
                     bus.dout, bus.busy, bus.din_ready, bus.sym_strobe, bus.underrun);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.dout !== 8'sd0 || bus.din_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_discard: busy=%b dout=%0d ready=%b expected 0 0 1", bus.busy, bus.dout, bus.din_ready);
            end
        end
        bus.din = 2'b00; bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = exp_m(2'd0, 2'(cyc - 1));
            checks++;
            if (bus.dout !== e) begin
                errors++;
                $display("FAIL mid_restart k=%0d: dout=%0d expected %0d", k, bus.dout, e);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.din       = 2'b00;
        bus.din_valid = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_gap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dqpsk_mod.md
Name: dqpsk_mod

Overview:
DQPSK transmitter that generates the 8 MHz real passband stream consumed by the carrier-recovery / DQPSK demodulator chain.
- Accepts Gray-coded dibits over a valid/ready handshake and differentially encodes them onto a 4-point constellation.
- Holds each symbol for SPS clocks as a rectangular pulse.
- Up-converts to an fs/4 (2 MHz) carrier using the exact sample sequence I, -Q, -I, Q, so no NCO or multiplier is needed.
- Output is 8-bit signed, the same format as the demodulator input.

Parameters:
SPS, 32, clocks per symbol (legal range >=2; 32 gives 250 ksym/s at 8 MHz).
AMP, 90, constellation amplitude per axis (legal range 1..127).

Ports:
clk  input  1  system clock, 8 MHz
reset_n  input  1  asynchronous reset, active-low
din  input  2  Gray dibit to transmit
din_valid  input  1  din is valid this cycle
din_ready  output  1  block can accept din this cycle
dout  output  8  signed passband sample, one per clock
busy  output  1  high while state is RUN
sym_strobe  output  1  1-cycle pulse, a new symbol was loaded
underrun  output  1  1-cycle pulse, RUN ended because no dibit was pending

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous, active-low; one clock domain only.
- Reset clears all registers: dout=0, busy=0, sym_strobe=0, underrun=0, buf_full=0 (so din_ready=1), differential phase p=0, symbol counter cnt=0, carrier counter c=0, state=IDLE.
- Reset asserted mid-operation aborts the current symbol immediately and discards any pending dibit; no partial output is resumed.
- Input buffer:
  - Buffer is a 1-deep holding register; din_ready = !buf_full, taken directly from a register.
  - On a clock edge with din_valid && din_ready: buf <= din, buf_full <= 1.
  - A write into a full buffer cannot occur because ready is low whenever the buffer is full.
  - Consuming the buffer clears buf_full at that same edge, so din_ready is high in the following cycle.
- Differential encoding:
  - Phase increment by dibit: 00 -> +0, 01 -> +1, 11 -> +2, 10 -> +3.
  - p <= p + inc, computed modulo 4 (2-bit wrap).
  - Constellation mapping p -> (I,Q): 0:(+AMP,+AMP), 1:(-AMP,+AMP), 2:(-AMP,-AMP), 3:(+AMP,-AMP).
- Carrier:
  - c is a 2-bit counter that increments every clock from reset, in every state; it is never re-aligned to symbol boundaries.
  - Mixed sample m by c: c=0: I; c=1: -Q; c=2: -I; c=3: Q.
  - Negation is exact because AMP<=127.
- Output register: dout <= (state==RUN) ? m : 0. dout therefore lags p, c and state by one clock.
- State machine (states IDLE and RUN):
  - IDLE: cnt held at 0. If buf_full at an edge:
    - p updates from buf; buf_full clears.
    - cnt <= 0; state <= RUN; sym_strobe <= 1.
  - RUN, cnt < SPS-1: cnt <= cnt+1.
  - RUN, cnt == SPS-1 with buf_full:
    - Load the next symbol exactly as in IDLE (p update, buf clear, cnt <= 0, sym_strobe pulse).
    - Symbols are back-to-back with no gap.
  - RUN, cnt == SPS-1 with buffer empty:
    - state <= IDLE, cnt <= 0, underrun <= 1 for one cycle.
    - p is retained, so the differential reference survives the gap.
  - A dibit arriving in the same cycle as the SPS-1 boundary, with the buffer empty, is registered at that edge but is not consumed at it. Underrun fires; the symbol is loaded from IDLE on the next edge, so output is zero for exactly 1 sample.
- busy = (state==RUN), registered.
- Every RUN symbol spans exactly SPS consecutive dout samples.
- First nonzero dout appears 2 clocks after the edge that captured the first dibit.
- cnt width: clog2(SPS).

Test Plan:
- Reset release, din_valid=0 -> dout=0, busy=0, din_ready=1 indefinitely; c still free-runs.
- Single dibit 00 after reset, AMP=90 -> p stays 0; 32 samples following c phase: c0 90, c1 -90, c2 -90, c3 90; then underrun pulse, busy=0, dout=0.
- Continuous stream 00,01,11,10,00 with valid held high -> p = 0,1,3,2,2. Symbol 2 (p=1) samples by c: -90,-90,90,90. Symbol 3 (p=3): 90,90,-90,-90. No gaps, exactly one sym_strobe per 32 clocks.
- Backpressure: hold din_valid=1 -> din_ready is low from load until the consuming edge and high exactly 1 cycle after each symbol load. No dibit is lost or duplicated (checked against a reference p sequence).
- Dibit presented only on the cycle cnt==SPS-1 with empty buffer -> underrun pulse, exactly one dout=0 sample, then the new symbol with p continuing from the previous value (not 0).
- reset_n pulsed low mid-symbol with buffer full -> outputs cleared asynchronously; after release the buffer is empty and p=0. The next dibit 00 yields the p=0 pattern again.
